muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO unit controller: single-cycle multiply and MTHI/MTLO, 32-cycle restoring divide.
// Divide stalls the pipeline from issue until the result is written.
module muldiv_ctrl (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        flush,
  output logic [63:0] hilo_o,
  output logic        we_o,
  output logic        stall_o,
  output logic        div_zero_o
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic        r_signA;
  logic        r_signB;
  logic [63:0] r_hilo;
  logic        r_we;
  logic        r_divZero;

  logic        w_accept;
  logic        w_isDiv;
  logic        w_divIssue;
  logic        w_signA;
  logic        w_signB;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [63:0] w_prodSigned;
  logic [63:0] w_prodUnsigned;
  logic [32:0] w_partial;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_nextRem;
  logic [31:0] w_nextQuo;
  logic [31:0] w_finalRem;
  logic [31:0] w_finalQuo;

  assign w_accept   = (r_state == IDLE) && op_valid && !flush;
  assign w_isDiv    = (op == OP_DIV) || (op == OP_DIVU);
  assign w_divIssue = w_accept && w_isDiv && (src_b != 32'd0);

  // Signs are only meaningful for DIV; DIVU works on raw magnitudes.
  assign w_signA = (op == OP_DIV) && src_a[31];
  assign w_signB = (op == OP_DIV) && src_b[31];
  assign w_absA  = w_signA ? (32'd0 - src_a) : src_a;
  assign w_absB  = w_signB ? (32'd0 - src_b) : src_b;

  assign w_prodSigned   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign w_prodUnsigned = {32'd0, src_a} * {32'd0, src_b};

  // Restoring step: bit 32 of the difference is the borrow, since rem < divisor.
  assign w_partial  = {r_rem, r_quo[31]};
  assign w_diff     = w_partial - {1'b0, r_divisor};
  assign w_fits     = !w_diff[32];
  assign w_nextRem  = w_fits ? w_diff[31:0] : w_partial[31:0];
  assign w_nextQuo  = {r_quo[30:0], w_fits};
  assign w_finalQuo = (r_signA ^ r_signB) ? (32'd0 - w_nextQuo) : w_nextQuo;
  assign w_finalRem = r_signA ? (32'd0 - w_nextRem) : w_nextRem;

  assign stall_o    = cpu_rst_n && (w_divIssue || (r_state == DIV_RUN));
  assign hilo_o     = r_hilo;
  assign we_o       = r_we;
  assign div_zero_o = r_divZero;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state   <= IDLE;
      r_count   <= 5'd0;
      r_divisor <= 32'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
      r_hilo    <= 64'd0;
      r_we      <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_divZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (op)
              OP_MULT: begin
                r_hilo <= w_prodSigned;
                r_we   <= 1'b1;
              end
              OP_MULTU: begin
                r_hilo <= w_prodUnsigned;
                r_we   <= 1'b1;
              end
              OP_MTHI: begin
                r_hilo <= {src_a, lo_i};
                r_we   <= 1'b1;
              end
              OP_MTLO: begin
                r_hilo <= {hi_i, src_a};
                r_we   <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (src_b == 32'd0) begin
                  r_divZero <= 1'b1;
                end else begin
                  r_rem     <= 32'd0;
                  r_quo     <= w_absA;
                  r_divisor <= w_absB;
                  r_signA   <= w_signA;
                  r_signB   <= w_signB;
                  r_count   <= 5'd0;
                  r_state   <= DIV_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= w_nextRem;
            r_quo   <= w_nextQuo;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) begin
              r_hilo  <= {w_finalRem, w_finalQuo};
              r_we    <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        // DONE always returns to IDLE, so a flush here needs no special case.
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush;
  logic [63:0] hilo_o;
  logic        we_o;
  logic        stall_o;
  logic        div_zero_o;

  int          total;
  int          bad;
  logic [63:0] expHilo;

  muldiv_ctrl dut (
    .cpu_clk_50M(cpu_clk_50M),
    .cpu_rst_n  (cpu_rst_n),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .flush      (flush),
    .hilo_o     (hilo_o),
    .we_o       (we_o),
    .stall_o    (stall_o),
    .div_zero_o (div_zero_o)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  // Architectural result of an operation, straight from the arithmetic definitions.
  function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned ur;
    logic [63:0]     res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = 64'(ua * ub);
      OP_DIV: begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        uq  = ua / ub;
        ur  = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      OP_MTHI:  res = {a, lo};
      OP_MTLO:  res = {hi, a};
      default:  res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] hi,
                               input logic [31:0] lo, input logic f);
    op_valid = v;
    op       = o;
    src_a    = a;
    src_b    = b;
    hi_i     = hi;
    lo_i     = lo;
    flush    = f;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 3'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge cpu_clk_50M);
    #2;
  endtask

  // Issues one operation and follows it to completion, checking every cycle.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    logic        isDiv;
    logic        isWrite;
    logic [63:0] exp;
    isDiv   = (o == OP_DIV) || (o == OP_DIVU);
    isWrite = (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MTHI) || (o == OP_MTLO);
    exp     = refResult(o, a, b, hi, lo);
    applyStimulus(1'b1, o, a, b, hi, lo, 1'b0);
    checkOutput("issueStall", {63'd0, stall_o}, {63'd0, isDiv && (b != 32'd0)});
    if (isDiv && (b != 32'd0)) begin
      for (int k = 1; k <= 32; k++) begin
        nextCycle();
        applyStimulus($urandom_range(0, 1) == 1, 3'($urandom), $urandom, $urandom,
                      $urandom, $urandom, 1'b0);
        checkOutput("runStall", {63'd0, stall_o}, 64'd1);
        checkOutput("runWe", {63'd0, we_o}, 64'd0);
      end
      nextCycle();
      applyStimulus(1'b1, OP_MULTU, $urandom, $urandom, $urandom, $urandom, 1'b0);
      checkOutput("doneStall", {63'd0, stall_o}, 64'd0);
      checkOutput("doneWe", {63'd0, we_o}, 64'd1);
      checkOutput("doneHilo", hilo_o, exp);
      expHilo = exp;
    end else begin
      nextCycle();
      applyIdle();
      checkOutput("nextStall", {63'd0, stall_o}, 64'd0);
      checkOutput("nextWe", {63'd0, we_o}, {63'd0, isWrite});
      checkOutput("nextDivZero", {63'd0, div_zero_o}, {63'd0, isDiv});
      if (isWrite) expHilo = exp;
      checkOutput("nextHilo", hilo_o, expHilo);
    end
    nextCycle();
    applyIdle();
    checkOutput("afterWe", {63'd0, we_o}, 64'd0);
    checkOutput("afterDivZero", {63'd0, div_zero_o}, 64'd0);
    checkOutput("afterHilo", hilo_o, expHilo);
  endtask

  initial begin
    int          weSeen;
    int          stallSeen;
    logic [2:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    total   = 0;
    bad     = 0;
    expHilo = 64'd0;

    // Reset holds everything at zero even with a divide presented.
    cpu_rst_n = 1'b0;
    applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    checkOutput("rstHilo", hilo_o, 64'd0);
    checkOutput("rstWe", {63'd0, we_o}, 64'd0);
    checkOutput("rstDivZero", {63'd0, div_zero_o}, 64'd0);
    checkOutput("rstStall", {63'd0, stall_o}, 64'd0);
    nextCycle();
    nextCycle();
    checkOutput("rstStallHeld", {63'd0, stall_o}, 64'd0);
    checkOutput("rstWeHeld", {63'd0, we_o}, 64'd0);
    applyIdle();
    cpu_rst_n = 1'b1;
    nextCycle();

    // Directed corner cases.
    runOp(OP_MULT, 32'hFFFF_FFFE, 32'd3, $urandom, $urandom);
    checkOutput("multValue", expHilo, 64'hFFFF_FFFF_FFFF_FFFA);
    runOp(OP_DIVU, 32'd100, 32'd7, $urandom, $urandom);
    checkOutput("divuHilo", hilo_o, 64'h0000_0002_0000_000E);
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, $urandom, $urandom);
    checkOutput("divNegHilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom);
    checkOutput("divWrapHilo", hilo_o, 64'h0000_0000_8000_0000);
    runOp(OP_DIV, 32'd5, 32'd0, $urandom, $urandom);
    runOp(OP_MTLO, 32'h0000_1234, $urandom, 32'h0000_00AA, $urandom);
    checkOutput("mtloHilo", hilo_o, 64'h0000_00AA_0000_1234);
    runOp(OP_MTHI, 32'hCAFE_F00D, $urandom, $urandom, 32'h1357_9BDF);
    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, $urandom);

    // Flush in IDLE suppresses both a multiply and a divide issue.
    applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, $urandom, $urandom, 1'b1);
    checkOutput("flushMulStall", {63'd0, stall_o}, 64'd0);
    nextCycle();
    applyStimulus(1'b1, OP_DIVU, 32'd50, 32'd3, $urandom, $urandom, 1'b1);
    checkOutput("flushMulWe", {63'd0, we_o}, 64'd0);
    checkOutput("flushMulHilo", hilo_o, expHilo);
    checkOutput("flushDivStall", {63'd0, stall_o}, 64'd0);
    nextCycle();
    applyIdle();
    checkOutput("flushDivNoRun", {63'd0, stall_o}, 64'd0);
    checkOutput("flushDivWe", {63'd0, we_o}, 64'd0);

    // Flush on DIV_RUN cycle 10 abandons the divide.
    applyStimulus(1'b1, OP_DIVU, 32'd1000, 32'd13, $urandom, $urandom, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      nextCycle();
      applyStimulus(1'b0, 3'd0, $urandom, $urandom, $urandom, $urandom, k == 10);
      checkOutput("preFlushStall", {63'd0, stall_o}, 64'd1);
    end
    nextCycle();
    applyIdle();
    checkOutput("postFlushStall", {63'd0, stall_o}, 64'd0);
    weSeen    = 0;
    stallSeen = 0;
    for (int k = 0; k < 30; k++) begin
      if (we_o !== 1'b0) weSeen++;
      if (stall_o !== 1'b0) stallSeen++;
      nextCycle();
      applyIdle();
    end
    checkOutput("postFlushNoWe", 64'(weSeen), 64'd0);
    checkOutput("postFlushNoStall", 64'(stallSeen), 64'd0);
    checkOutput("postFlushHilo", hilo_o, expHilo);
    runOp(OP_DIV, 32'hFFFF_FC18, 32'd7, $urandom, $urandom);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(1'b1, OP_DIVU, $urandom, 32'd77, $urandom, $urandom, 1'b0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      applyIdle();
    end
    #3;
    cpu_rst_n = 1'b0;
    #1;
    checkOutput("midRstHilo", hilo_o, 64'd0);
    checkOutput("midRstWe", {63'd0, we_o}, 64'd0);
    checkOutput("midRstStall", {63'd0, stall_o}, 64'd0);
    checkOutput("midRstDivZero", {63'd0, div_zero_o}, 64'd0);
    nextCycle();
    cpu_rst_n = 1'b1;
    expHilo   = 64'd0;
    weSeen    = 0;
    stallSeen = 0;
    for (int k = 0; k < 40; k++) begin
      nextCycle();
      applyIdle();
      if (we_o !== 1'b0) weSeen++;
      if (stall_o !== 1'b0) stallSeen++;
    end
    checkOutput("postRstNoWe", 64'(weSeen), 64'd0);
    checkOutput("postRstNoStall", 64'(stallSeen), 64'd0);
    checkOutput("postRstHilo", hilo_o, 64'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 30; n++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = $urandom;
      case ($urandom_range(0, 5))
        0:       rB = 32'd0;
        1:       rB = 32'($urandom_range(1, 20));
        2:       rB = 32'hFFFF_FFFF;
        default: rB = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) rA = 32'h8000_0000;
      runOp(rOp, rA, rB, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
